// File: rtl/sub_bitfield_extract_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_bitfield_extract_pkg
// Description : Shared helpers for the bit-field extractor: ceil-log2,
//               derived offset/length widths, action-slice width and the
//               per-channel slice index helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sub_bitfield_extract_pkg;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Offset width for a header slice of hdr_len bits (at least one bit).
    function automatic int off_w(input int hdr_len);
        return (clog2(hdr_len) < 1) ? 1 : clog2(hdr_len);
    endfunction

    // Length width: must be able to encode FIELD_W itself, hence the +1.
    function automatic int len_w(input int field_w);
        return clog2(field_w) + 1;
    endfunction

    // Width of one per-channel action word {off, len}.
    function automatic int act_w(input int hdr_len, input int field_w);
        return off_w(hdr_len) + len_w(field_w);
    endfunction

    // LSB index of channel c inside a bus made of w-bit channel slices.
    function automatic int ch_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage : sub_bitfield_extract_pkg
`default_nettype wire

// File: rtl/sub_bitfield_extract_ch.sv
`default_nettype none
// ============================================================================
// Module      : sub_bitfield_ch
// Description : One combinational extraction channel. Takes len bits starting
//               at offset off (offset 0 = header MSB), right-justifies and
//               zero-extends them, and flags out-of-range requests.
// Ports       : hdr_i   - header slice
//               off_i   - field offset, MSB-first
//               len_i   - field length in bits (0..FIELD_W valid)
//               field_o - extracted field, forced to 0 on error
//               err_o   - range error
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bitfield_ch #(
    parameter int SUB_PKTS_LEN = 32,
    parameter int FIELD_W      = 8,
    parameter int OFF_W        = 5,
    parameter int LEN_W        = 4
) (
    input  logic [SUB_PKTS_LEN-1:0] hdr_i,
    input  logic [OFF_W-1:0]        off_i,
    input  logic [LEN_W-1:0]        len_i,
    output logic [FIELD_W-1:0]      field_o,
    output logic                    err_o
);

    // Two extra bits keep off+len from wrapping.
    localparam int                SUM_W     = OFF_W + 2;
    localparam logic [SUM_W-1:0]  c_HDR_LEN = SUM_W'(SUB_PKTS_LEN);
    localparam logic [LEN_W-1:0]  c_FIELD_W = LEN_W'(FIELD_W);

    logic [SUM_W-1:0]        w_end;
    logic                    w_err;
    logic [SUB_PKTS_LEN-1:0] w_shl;
    logic [FIELD_W-1:0]      w_top;
    logic [LEN_W-1:0]        w_rsh;
    logic [FIELD_W-1:0]      w_field;

    assign w_end = SUM_W'(off_i) + SUM_W'(len_i);
    assign w_err = (len_i > c_FIELD_W) || (w_end > c_HDR_LEN);

    // Move the first field bit to the MSB, take a FIELD_W window, then
    // shift right so only len bits remain (right-justified, zero-filled).
    assign w_shl   = hdr_i << off_i;
    assign w_top   = w_shl[SUB_PKTS_LEN-1 -: FIELD_W];
    assign w_rsh   = c_FIELD_W - len_i;
    assign w_field = w_top >> w_rsh;

    assign field_o = (w_err || (len_i == '0)) ? '0 : w_field;
    assign err_o   = w_err;

endmodule : sub_bitfield_ch
`default_nettype wire

// File: rtl/sub_bitfield_extract.sv
`default_nettype none
// ============================================================================
// Module      : sub_bitfield_extract
// Description : NUM_CH-channel bit-field extractor, 2-stage valid/ready
//               pipeline. S1 registers the header/actions/mask; S2 runs the
//               channel extractors and registers fields, mask, errors and a
//               saturating count of beats carrying any error.
// Ports       : clk, aresetn (sync, active-low)
//               i_valid/o_in_ready   - upstream handshake
//               i_hdr, i_act, i_mask - header, per-channel {off,len}, mask
//               o_valid/i_out_ready  - downstream handshake
//               o_field, o_mask, o_err, o_err_cnt - results
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bitfield_extract
    import sub_bitfield_extract_pkg::*;
#(
    parameter  int SUB_PKTS_LEN = 32,
    parameter  int NUM_CH       = 4,
    parameter  int FIELD_W      = 8,
    parameter  int CNT_W        = 16,
    localparam int OFF_W        = off_w(SUB_PKTS_LEN),
    localparam int LEN_W        = len_w(FIELD_W)
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic                           i_valid,
    output logic                           o_in_ready,
    input  logic [SUB_PKTS_LEN-1:0]        i_hdr,
    input  logic [NUM_CH*(OFF_W+LEN_W)-1:0] i_act,
    input  logic [NUM_CH-1:0]              i_mask,
    output logic                           o_valid,
    input  logic                           i_out_ready,
    output logic [NUM_CH*FIELD_W-1:0]      o_field,
    output logic [NUM_CH-1:0]              o_mask,
    output logic [NUM_CH-1:0]              o_err,
    output logic [CNT_W-1:0]               o_err_cnt
);

    localparam int ACT_W = OFF_W + LEN_W;

    // Handshake / control
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;
    logic s1_valid_q, s1_valid_d;
    logic o_valid_q,  o_valid_d;

    // Stage-1 data
    logic [SUB_PKTS_LEN-1:0]   s1_hdr_q;
    logic [NUM_CH*ACT_W-1:0]   s1_act_q;
    logic [NUM_CH-1:0]         s1_mask_q;

    // Stage-2 data
    logic [NUM_CH*FIELD_W-1:0] w_field;
    logic [NUM_CH-1:0]         w_err;
    logic [NUM_CH*FIELD_W-1:0] field_q;
    logic [NUM_CH-1:0]         mask_q;
    logic [NUM_CH-1:0]         err_q;
    logic [CNT_W-1:0]          err_cnt_q, err_cnt_d;

    assign w_s2_adv   = !o_valid_q || i_out_ready;
    assign w_s1_adv   = s1_valid_q && w_s2_adv;
    assign o_in_ready = !s1_valid_q || w_s2_adv;
    assign w_accept   = i_valid && o_in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (w_accept) begin
            s1_valid_d = 1'b1;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end

        o_valid_d = o_valid_q;
        if (w_s1_adv) begin
            o_valid_d = 1'b1;
        end else if (i_out_ready) begin
            o_valid_d = 1'b0;
        end

        // One increment per erroneous beat regardless of how many channels
        // failed; sticks at all-ones until reset.
        err_cnt_d = err_cnt_q;
        if (w_s1_adv && (|w_err) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            o_valid_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            o_valid_q  <= o_valid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            s1_hdr_q  <= i_hdr;
            s1_act_q  <= i_act;
            s1_mask_q <= i_mask;
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            sub_bitfield_ch #(
                .SUB_PKTS_LEN (SUB_PKTS_LEN),
                .FIELD_W      (FIELD_W),
                .OFF_W        (OFF_W),
                .LEN_W        (LEN_W)
            ) u_ch (
                .hdr_i   (s1_hdr_q),
                .off_i   (s1_act_q[ch_lsb(c, ACT_W) + LEN_W +: OFF_W]),
                .len_i   (s1_act_q[ch_lsb(c, ACT_W) +: LEN_W]),
                .field_o (w_field[ch_lsb(c, FIELD_W) +: FIELD_W]),
                .err_o   (w_err[c])
            );
        end
    endgenerate

    // Output registers only load on an S1->S2 transfer, which keeps them
    // stable while the downstream stalls.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            field_q <= '0;
            mask_q  <= '0;
            err_q   <= '0;
        end else if (w_s1_adv) begin
            field_q <= w_field;
            mask_q  <= s1_mask_q;
            err_q   <= w_err;
        end
    end

    assign o_valid   = o_valid_q;
    assign o_field   = field_q;
    assign o_mask    = mask_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;

endmodule : sub_bitfield_extract
`default_nettype wire

// File: tb/tb_sub_bitfield_extract.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bitfield_extract
// Description : Self-checking bench: default 4-channel configuration plus an
//               8-bit / 1-channel / 1-bit-field compatibility instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bitfield_extract;

    logic clk;
    logic aresetn;

    // Default configuration: L=32, NUM_CH=4, FIELD_W=8 -> act slice 9 bits
    logic        i_valid;
    logic        o_in_ready;
    logic [31:0] i_hdr;
    logic [35:0] i_act;
    logic [3:0]  i_mask;
    logic        o_valid;
    logic        i_out_ready;
    logic [31:0] o_field;
    logic [3:0]  o_mask;
    logic [3:0]  o_err;
    logic [15:0] o_err_cnt;

    // Compatibility configuration: L=8, NUM_CH=1, FIELD_W=1 -> act slice 4 bits
    logic        i_valid8;
    logic        o_in_ready8;
    logic [7:0]  i_hdr8;
    logic [3:0]  i_act8;
    logic [0:0]  i_mask8;
    logic        o_valid8;
    logic        i_out_ready8;
    logic [0:0]  o_field8;
    logic [0:0]  o_mask8;
    logic [0:0]  o_err8;
    logic [15:0] o_err_cnt8;

    int n_cmp = 0;
    int n_bad = 0;

    sub_bitfield_extract #(
        .SUB_PKTS_LEN (32),
        .NUM_CH       (4),
        .FIELD_W      (8),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .i_hdr       (i_hdr),
        .i_act       (i_act),
        .i_mask      (i_mask),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_field     (o_field),
        .o_mask      (o_mask),
        .o_err       (o_err),
        .o_err_cnt   (o_err_cnt)
    );

    sub_bitfield_extract #(
        .SUB_PKTS_LEN (8),
        .NUM_CH       (1),
        .FIELD_W      (1),
        .CNT_W        (16)
    ) dut8 (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_valid     (i_valid8),
        .o_in_ready  (o_in_ready8),
        .i_hdr       (i_hdr8),
        .i_act       (i_act8),
        .i_mask      (i_mask8),
        .o_valid     (o_valid8),
        .i_out_ready (i_out_ready8),
        .o_field     (o_field8),
        .o_mask      (o_mask8),
        .o_err       (o_err8),
        .o_err_cnt   (o_err_cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp_v);
        end
    endtask

    function automatic logic [8:0] mk_act(input int off, input int len);
        logic [4:0] o;
        logic [3:0] l;
        o = off[4:0];
        l = len[3:0];
        return {o, l};
    endfunction

    typedef struct {
        logic [31:0] hdr;
        logic [35:0] act;
        logic [3:0]  mask;
        logic [31:0] field;
        logic [3:0]  err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0]  exp8;
        logic [35:0] act_ok;
        logic [35:0] act_bad;
        logic [31:0] snap;
        int sent, got, stall, first_cyc, last_cyc, n_out;
        logic saw_block, stray;

        // {ch3, ch2, ch1, ch0}; fields listed the same way
        vecs[0] = '{32'hDEADBEEF, {mk_act(12,0), mk_act(28,4), mk_act(4,8),  mk_act(0,8)},
                    4'b1010, 32'h000F_EADE, 4'b0000, 16'd0};
        vecs[1] = '{32'hDEADBEEF, {mk_act(24,8), mk_act(0,9),  mk_act(30,4), mk_act(0,8)},
                    4'b0101, 32'hEF00_00DE, 4'b0110, 16'd1};
        vecs[2] = '{32'h12345678, {mk_act(28,3), mk_act(3,5),  mk_act(31,1), mk_act(8,8)},
                    4'b1111, 32'h0412_0034, 4'b0000, 16'd1};
        vecs[3] = '{32'hFFFFFFFF, {mk_act(16,1), mk_act(0,15), mk_act(25,7), mk_act(31,2)},
                    4'b0000, 32'h0100_7F00, 4'b0101, 16'd2};
        vecs[4] = '{32'h80000001, {mk_act(24,8), mk_act(1,8),  mk_act(31,1), mk_act(0,1)},
                    4'b0011, 32'h0100_0101, 4'b0000, 16'd2};
        act_ok  = vecs[2].act;
        act_bad = vecs[1].act;

        aresetn      = 1'b0;
        i_valid      = 1'b0;
        i_hdr        = '0;
        i_act        = '0;
        i_mask       = '0;
        i_out_ready  = 1'b1;
        i_valid8     = 1'b0;
        i_hdr8       = '0;
        i_act8       = '0;
        i_mask8      = '0;
        i_out_ready8 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("rst_o_valid",   {31'd0, o_valid},    32'd0);
        check("rst_o_field",   o_field,             32'd0);
        check("rst_o_mask",    {28'd0, o_mask},     32'd0);
        check("rst_o_err",     {28'd0, o_err},      32'd0);
        check("rst_o_err_cnt", {16'd0, o_err_cnt},  32'd0);
        check("rst_in_ready",  {31'd0, o_in_ready}, 32'd1);

        // ---- compatibility instance: single-bit selector behaviour ----
        exp8 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            i_valid8 = 1'b1;
            i_hdr8   = 8'hA5;
            i_act8   = {k[2:0], 1'b1};
            i_mask8  = k[0];
            @(posedge clk); #1;
            i_valid8 = 1'b0;
            check($sformatf("compat_lat1_off%0d", k), {31'd0, o_valid8}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("compat_valid_off%0d", k), {31'd0, o_valid8}, 32'd1);
            check($sformatf("compat_field_off%0d", k), {31'd0, o_field8}, {31'd0, exp8[7-k]});
            check($sformatf("compat_mask_off%0d", k),  {31'd0, o_mask8},  {31'd0, k[0]});
            check($sformatf("compat_err_off%0d", k),   {31'd0, o_err8},   32'd0);
        end
        check("compat_err_cnt", {16'd0, o_err_cnt8}, 32'd0);

        // ---- table-driven vectors, one beat at a time, exact latency ----
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            i_valid = 1'b1;
            i_hdr   = vecs[v].hdr;
            i_act   = vecs[v].act;
            i_mask  = vecs[v].mask;
            @(posedge clk); #1;
            i_valid = 1'b0;
            check($sformatf("vec%0d_lat1", v), {31'd0, o_valid}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", v), {31'd0, o_valid},   32'd1);
            check($sformatf("vec%0d_field", v), o_field,            vecs[v].field);
            check($sformatf("vec%0d_mask", v),  {28'd0, o_mask},    {28'd0, vecs[v].mask});
            check($sformatf("vec%0d_err", v),   {28'd0, o_err},     {28'd0, vecs[v].err});
            check($sformatf("vec%0d_cnt", v),   {16'd0, o_err_cnt}, {16'd0, vecs[v].cnt});
        end

        // ---- full rate: 20 beats, ready always high ----
        n_out = 0; first_cyc = -1; last_cyc = -1;
        i_act = act_ok; i_mask = 4'b0001; i_out_ready = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk); #1;
            i_valid = (cyc < 20);
            i_hdr   = {8'h00, 8'(cyc), 16'h0000};
            @(negedge clk);
            if (cyc < 20) check($sformatf("full_in_ready_c%0d", cyc), {31'd0, o_in_ready}, 32'd1);
            if (o_valid) begin
                check($sformatf("full_field_%0d", n_out), {24'd0, o_field[7:0]}, n_out);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
            end
        end
        check("full_count",       n_out,                 32'd20);
        check("full_consecutive", last_cyc - first_cyc,  32'd19);

        // ---- backpressure: 6 beats, 3 stall cycles at first output ----
        sent = 0; got = 0; stall = 0; saw_block = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(posedge clk); #1;
            i_valid     = (sent < 6);
            i_hdr       = {8'h00, 8'(8'h40 + sent), 16'h0000};
            i_out_ready = (stall >= 3);
            @(negedge clk);
            if (i_valid && !o_in_ready) saw_block = 1'b1;
            if (o_valid && !i_out_ready) begin
                if (stall == 0) snap = o_field;
                else check($sformatf("bp_stable_%0d", stall), o_field, snap);
                stall++;
            end else if (o_valid && i_out_ready) begin
                check($sformatf("bp_order_%0d", got), {24'd0, o_field[7:0]}, 32'h40 + got);
                got++;
            end
            if (i_valid && o_in_ready) sent++;
        end
        check("bp_first_held", {24'd0, snap[7:0]}, 32'h40);
        check("bp_delivered",  got,                32'd6);
        check("bp_stalls",     stall,              32'd3);
        check("bp_in_ready_low_seen", {31'd0, saw_block}, 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_valid) stray = 1'b1;
        end
        check("bp_no_duplicate", {31'd0, stray}, 32'd0);

        // ---- reset with two beats in flight ----
        @(posedge clk); #1;
        i_valid = 1'b1; i_hdr = 32'hDEADBEEF; i_act = act_bad;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("rmid_pre_valid", {31'd0, o_valid}, 32'd1);
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        check("rmid_o_valid",   {31'd0, o_valid},    32'd0);
        check("rmid_err_cnt",   {16'd0, o_err_cnt},  32'd0);
        check("rmid_in_ready",  {31'd0, o_in_ready}, 32'd1);
        check("rmid_o_field",   o_field,             32'd0);
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid) stray = 1'b1;
        end
        check("rmid_no_stale", {31'd0, stray}, 32'd0);

        // ---- error counter saturation: 65536 error beats ----
        @(posedge clk); #1;
        i_valid = 1'b1; i_hdr = 32'hDEADBEEF; i_act = act_bad;
        repeat (65536) @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_err_cnt", {16'd0, o_err_cnt}, 32'h0000_FFFF);
        check("sat_err_bits", {28'd0, o_err}, 32'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sub_bitfield_extract
`default_nettype wire
